inst_fetch_buffer: RTL and testbench
====================================

Name: inst_fetch_buffer

Overview:
- Instruction queue between the fetch stage (ICache return) and the two parallel ID decoders.
- Accepts up to two fetched instructions per cycle and presents the two oldest as decoder slot 0 and slot 1.
- Each slot drives the IF_IR / PC / data_valid triple that a decoder consumes.
- Absorbs fetch/issue rate mismatch and empties on a pipeline flush (branch mispredict, exception).

Parameters:
- DEPTH, 8, number of instruction entries; power of two, at least 4.
- PTR_W, $clog2(DEPTH), pointer width; derived, do not override.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  discard all entries; ignore this cycle's enqueue
- i_valid  in  1  fetch pair valid this cycle
- i_pc  in  32  PC of i_inst0; i_inst1 is at i_pc+4
- i_inst0  in  32  first fetched instruction
- i_inst1  in  32  second fetched instruction
- i_inst1_valid  in  1  i_inst1 present; ignored unless i_valid=1
- o_ready  out  1  buffer can accept a full pair this cycle
- IF_IR0  out  32  slot 0 instruction (oldest)
- PC0  out  32  slot 0 PC
- data_valid0  out  1  slot 0 holds a live entry
- IF_IR1  out  32  slot 1 instruction (second oldest)
- PC1  out  32  slot 1 PC
- data_valid1  out  1  slot 1 holds a live entry
- deq0  in  1  ID consumes slot 0 this cycle
- deq1  in  1  ID consumes slot 1 this cycle; legal only together with deq0

Interface decision: one clock (clk); reset is asynchronous and active-high (rst).

Behaviour:
- Storage: circular array of {inst[31:0], pc[31:0]}, head/tail pointers PTR_W bits wide, count register PTR_W+1 bits wide.
- Reset (async assert): head=0, tail=0, count=0, so o_ready=1, data_valid0=0, data_valid1=0. IF_IR*/PC* are don't-care while invalid; the bench checks them only when the matching valid=1.
- Outputs are combinational reads of the registered array:
  - slot 0 = entry[head], slot 1 = entry[head+1 mod DEPTH]
  - data_valid0 = (count>=1), data_valid1 = (count>=2)
- o_ready = (DEPTH - count) >= 2, computed from the registered count only. A same-cycle dequeue never raises o_ready.
- Enqueue happens when i_valid & o_ready & ~flush:
  - write entry[tail] = {i_inst0, i_pc}
  - if i_inst1_valid, also write entry[tail+1] = {i_inst1, i_pc+4}
  - tail advances by 1 or 2
- i_valid while o_ready=0: the pair is dropped with no state change. Fetch must hold its data and retry.
- Dequeue count n = deq0 + (deq0 & deq1), masked by validity: deq0 counts only if data_valid0, deq1 only if data_valid1. head advances by n.
- Enqueue and dequeue in the same cycle: count_next = count + enq_n - n.
- Latency: an enqueued entry appears on the outputs on the cycle after its write edge. There is no bypass when empty.
- Wrap-around: all pointer arithmetic is modulo DEPTH. A pair may straddle the last index and index 0.
- Ordering: strict FIFO. Slot 0 is always older than slot 1.
- flush: at the next edge head=tail=0 and count=0. Any enqueue or dequeue that same cycle is discarded. Flush takes priority over every other event.
- rst asserted mid-operation clears state immediately, independent of clk.
- deq1 without deq0 is illegal: the block treats it as n=0. An assertion flags it in simulation.
- Full: with count=DEPTH-1, o_ready=0 even if only one instruction is offered.

Optional Feature:
- Macro IFB_ADEF_EN adds fetch-address-error tagging.
- With the macro defined:
  - each entry gains an adef bit = (pc[1:0] != 2'b00), written at enqueue
  - extra outputs o_adef0 and o_adef1 (1 bit each) follow slot 0 and slot 1
  - an entry with adef=1 is still queued normally; ID converts it to an exception
- Without the macro: no adef storage, no o_adef ports, behaviour otherwise identical.

Test Plan:
- Reset, then idle → o_ready=1, data_valid0=0, data_valid1=0. Assert rst asynchronously mid-cycle with 3 entries held → count=0 immediately.
- Enqueue pair pc=0x1C000000, inst0=0x02800421, inst1=0x00150085, i_inst1_valid=1, with no deq → next cycle PC0=0x1C000000, IF_IR0=0x02800421, PC1=0x1C000004, data_valid1=1.
- Fill with DEPTH=8:
  - enqueue 3 pairs plus 1 single → count=7, o_ready=0
  - offer a pair → dropped, count stays 7
  - deq0 & deq1 → count=5, o_ready=1 on the following cycle
- Wrap: drive head=tail=7 via enq/deq traffic, then enqueue pair pc=0x100 → entry[7] pc=0x100 and entry[0] pc=0x104, read out in order.
- Simultaneous: count=2, enqueue pair and deq0 only → count=3, slot 0 is the old second entry.
- Flush asserted together with i_valid and deq0 at count=4 → next cycle count=0, data_valid0=0. With IFB_ADEF_EN, a following enqueue at pc=0x1C000002 → o_adef0=1.

Source files
------------

// File: rtl/inst_fetch_buffer.sv
// Instruction fetch buffer: circular queue feeding two parallel ID decoders.
// Optional fetch-address-error tagging is enabled with `define IFB_ADEF_EN.
module inst_fetch_buffer #(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        i_valid,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_inst0,
    input  logic [31:0] i_inst1,
    input  logic        i_inst1_valid,
    output logic        o_ready,
    output logic [31:0] IF_IR0,
    output logic [31:0] PC0,
    output logic        data_valid0,
    output logic [31:0] IF_IR1,
    output logic [31:0] PC1,
    output logic        data_valid1,
`ifdef IFB_ADEF_EN
    output logic        o_adef0,
    output logic        o_adef1,
`endif
    input  logic        deq0,
    input  logic        deq1
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] ONE_C   = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] TWO_C   = (PTR_W+1)'(2);

    logic [31:0]      mem_inst [DEPTH];
    logic [31:0]      mem_pc   [DEPTH];
`ifdef IFB_ADEF_EN
    logic             mem_adef [DEPTH];
`endif

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;

    logic [PTR_W-1:0] head_p1;
    logic [PTR_W-1:0] tail_p1;
    logic             enq;
    logic [PTR_W:0]   enq_n;
    logic [PTR_W:0]   deq_n;

    assign head_p1 = head + 1'b1;
    assign tail_p1 = tail + 1'b1;

    // Readiness and validity depend only on the registered count.
    assign o_ready     = (DEPTH_C - count) >= TWO_C;
    assign data_valid0 = count >= ONE_C;
    assign data_valid1 = count >= TWO_C;

    assign IF_IR0 = mem_inst[head];
    assign PC0    = mem_pc[head];
    assign IF_IR1 = mem_inst[head_p1];
    assign PC1    = mem_pc[head_p1];
`ifdef IFB_ADEF_EN
    assign o_adef0 = mem_adef[head];
    assign o_adef1 = mem_adef[head_p1];
`endif

    // Work out how many entries enter and leave this cycle.
    always_comb begin
        enq   = i_valid & o_ready & ~flush;
        enq_n = '0;
        deq_n = '0;
        if (enq) begin
            enq_n = i_inst1_valid ? TWO_C : ONE_C;
        end
        if (deq0 && data_valid0) begin
            deq_n = (deq1 && data_valid1) ? TWO_C : ONE_C;
        end
    end

    // Pointer and occupancy state; flush wins over enqueue and dequeue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + deq_n[PTR_W-1:0];
            tail  <= tail + enq_n[PTR_W-1:0];
            count <= count + enq_n - deq_n;
        end
    end

    // Entry storage; a pair may straddle the last index and index 0.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_inst[tail] <= i_inst0;
            mem_pc[tail]   <= i_pc;
`ifdef IFB_ADEF_EN
            mem_adef[tail] <= i_pc[1:0] != 2'b00;
`endif
            if (i_inst1_valid) begin
                mem_inst[tail_p1] <= i_inst1;
                mem_pc[tail_p1]   <= i_pc + 32'd4;
`ifdef IFB_ADEF_EN
                mem_adef[tail_p1] <= i_pc[1:0] != 2'b00;
`endif
            end
        end
    end

    a_deq1_needs_deq0 : assert property (
        @(posedge clk) disable iff (rst) !(deq1 && !deq0)
    );

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Randomised and directed bench for inst_fetch_buffer.
// A queue-based reference model is compared against the DUT every cycle.
module tb_inst_fetch_buffer;

    localparam int DEPTH = 8;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        i_valid;
    logic [31:0] i_pc;
    logic [31:0] i_inst0;
    logic [31:0] i_inst1;
    logic        i_inst1_valid;
    logic        o_ready;
    logic [31:0] IF_IR0;
    logic [31:0] PC0;
    logic        data_valid0;
    logic [31:0] IF_IR1;
    logic [31:0] PC1;
    logic        data_valid1;
`ifdef IFB_ADEF_EN
    logic        o_adef0;
    logic        o_adef1;
`endif
    logic        deq0;
    logic        deq1;

    ent_t q[$];
    int   checks = 0;
    int   errors = 0;

    inst_fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .i_valid      (i_valid),
        .i_pc         (i_pc),
        .i_inst0      (i_inst0),
        .i_inst1      (i_inst1),
        .i_inst1_valid(i_inst1_valid),
        .o_ready      (o_ready),
        .IF_IR0       (IF_IR0),
        .PC0          (PC0),
        .data_valid0  (data_valid0),
        .IF_IR1       (IF_IR1),
        .PC1          (PC1),
        .data_valid1  (data_valid1),
`ifdef IFB_ADEF_EN
        .o_adef0      (o_adef0),
        .o_adef1      (o_adef1),
`endif
        .deq0         (deq0),
        .deq1         (deq1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference behaviour: a plain FIFO of {inst, pc}.
    task automatic model_update();
        int sz;
        int n;
        bit rdy;
        sz = q.size();
        if (rst || flush) begin
            q.delete();
            return;
        end
        rdy = (DEPTH - sz) >= 2;
        n = 0;
        if (deq0 && sz >= 1) n = 1;
        if (deq0 && deq1 && sz >= 2) n = 2;
        repeat (n) void'(q.pop_front());
        if (i_valid && rdy) begin
            q.push_back({i_inst0, i_pc});
            if (i_inst1_valid) q.push_back({i_inst1, i_pc + 32'd4});
        end
    endtask

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        chk("o_ready", {31'd0, o_ready},
            {31'd0, (DEPTH - q.size()) >= 2});
        chk("data_valid0", {31'd0, data_valid0}, {31'd0, q.size() >= 1});
        chk("data_valid1", {31'd0, data_valid1}, {31'd0, q.size() >= 2});
        if (q.size() >= 1 && data_valid0) begin
            chk("IF_IR0", IF_IR0, q[0].inst);
            chk("PC0", PC0, q[0].pc);
`ifdef IFB_ADEF_EN
            chk("o_adef0", {31'd0, o_adef0}, {31'd0, q[0].pc[1:0] != 2'b00});
`endif
        end
        if (q.size() >= 2 && data_valid1) begin
            chk("IF_IR1", IF_IR1, q[1].inst);
            chk("PC1", PC1, q[1].pc);
`ifdef IFB_ADEF_EN
            chk("o_adef1", {31'd0, o_adef1}, {31'd0, q[1].pc[1:0] != 2'b00});
`endif
        end
    end

    task automatic drive(input logic v, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic v1, input logic d0, input logic d1,
                         input logic fl);
        i_valid       = v;
        i_pc          = pc;
        i_inst0       = a;
        i_inst1       = b;
        i_inst1_valid = v1;
        deq0          = d0;
        deq1          = d1;
        flush         = fl;
    endtask

    task automatic idle();
        drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
        chk("rst o_ready", {31'd0, o_ready}, 32'd1);
        chk("rst dv0", {31'd0, data_valid0}, 32'd0);
        chk("rst dv1", {31'd0, data_valid1}, 32'd0);

        // First pair lands on the outputs one cycle after its write.
        drive(1, 32'h1C000000, 32'h02800421, 32'h00150085, 1, 0, 0, 0);
        tick();
        idle();
        chk("pair PC0", PC0, 32'h1C000000);
        chk("pair IR0", IF_IR0, 32'h02800421);
        chk("pair PC1", PC1, 32'h1C000004);
        chk("pair IR1", IF_IR1, 32'h00150085);
        chk("pair dv1", {31'd0, data_valid1}, 32'd1);

        // Enqueue pair while dequeuing one at count 2.
        drive(1, 32'h00000200, 32'hAAAA0001, 32'hAAAA0002, 1, 1, 0, 0);
        tick();
        idle();
        chk("simul size", q.size(), 32'd3);
        chk("simul PC0", PC0, 32'h1C000004);
        chk("simul IR0", IF_IR0, 32'h00150085);
        chk("simul PC1", PC1, 32'h00000200);

        // Fill to DEPTH-1: three pairs and a single.
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h1000 + 32'(i * 8), 32'hB000 + 32'(i * 2),
                  32'hB001 + 32'(i * 2), i < 3, 0, 0, 0);
            tick();
        end
        idle();
        chk("full size", q.size(), 32'd7);
        chk("full o_ready", {31'd0, o_ready}, 32'd0);
        drive(1, 32'h2000, 32'hDEAD0000, 32'hDEAD0001, 1, 0, 0, 0);
        tick();
        idle();
        chk("drop size", q.size(), 32'd7);
        chk("drop dv1", {31'd0, data_valid1}, 32'd1);
        drive(0, 0, 0, 0, 0, 1, 1, 0);
        #1;
        chk("deq no bypass rdy", {31'd0, o_ready}, 32'd0);
        tick();
        idle();
        chk("after deq2 size", q.size(), 32'd5);
        chk("after deq2 o_ready", {31'd0, o_ready}, 32'd1);
        chk("after deq2 PC0", PC0, 32'h00001008);

        // Flush beats simultaneous enqueue and dequeue.
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        chk("pre-flush size", q.size(), 32'd4);
        drive(1, 32'h4000, 32'hC0, 32'hC1, 1, 1, 0, 1);
        tick();
        idle();
        chk("flush dv0", {31'd0, data_valid0}, 32'd0);
        chk("flush o_ready", {31'd0, o_ready}, 32'd1);
        drive(1, 32'h1C000002, 32'h0000CAFE, 32'h0, 0, 0, 0, 0);
        tick();
        idle();
        chk("misal PC0", PC0, 32'h1C000002);
`ifdef IFB_ADEF_EN
        chk("misal adef0", {31'd0, o_adef0}, 32'd1);
`endif

        // Asynchronous reset with three entries held.
        drive(1, 32'h3000, 32'hE0, 32'hE1, 1, 0, 0, 0);
        tick();
        idle();
        chk("pre-rst size", q.size(), 32'd3);
        #2;
        rst = 1'b1;
        q.delete();
        #1;
        chk("async rst dv0", {31'd0, data_valid0}, 32'd0);
        chk("async rst dv1", {31'd0, data_valid1}, 32'd0);
        chk("async rst rdy", {31'd0, o_ready}, 32'd1);
        tick();
        rst = 1'b0;

        // Move head and tail to 7, then write a pair that wraps.
        drive(1, 32'h500, 32'hF0, 32'h0, 0, 0, 0, 0);
        tick();
        for (int i = 1; i < 7; i++) begin
            drive(1, 32'h500 + 32'(i * 4), 32'hF0 + 32'(i), 32'h0, 0, 1, 0, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        chk("wrap pre size", q.size(), 32'd0);
        drive(1, 32'h100, 32'h11111111, 32'h22222222, 1, 0, 0, 0);
        tick();
        idle();
        chk("wrap PC0", PC0, 32'h00000100);
        chk("wrap PC1", PC1, 32'h00000104);
        chk("wrap IR1", IF_IR1, 32'h22222222);
        drive(0, 0, 0, 0, 0, 1, 1, 0);
        tick();
        idle();
        chk("wrap drained", {31'd0, data_valid0}, 32'd0);

        // Random traffic with alternating fill/drain bias.
        for (int c = 0; c < 3000; c++) begin
            logic d0;
            logic [31:0] pc;
            pc = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) pc[1:0] = 2'($urandom_range(1, 3));
            if (((c / 200) % 2) == 0) d0 = $urandom_range(0, 3) == 0;
            else d0 = $urandom_range(0, 3) != 0;
            drive($urandom_range(0, 3) != 0, pc, $urandom(), $urandom(),
                  $urandom_range(0, 1) == 1, d0,
                  d0 & ($urandom_range(0, 1) == 1),
                  $urandom_range(0, 63) == 0);
            tick();
        end
        idle();
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
